mult4u_tr_sched: RTL and testbench
==================================

Name: mult4u_tr_sched

Overview:
- Time-redundant scheduler that shares one external combinational unsigned 4x4 multiplier (8-bit product) between two requesters.
- Each accepted operation is evaluated twice: once with operands (A,B), once swapped (B,A). The two products are compared, and a third evaluation with majority vote runs on mismatch.
- Sits between client logic and the fault-resilient multiplier netlist, converting transient multiplier faults into corrected results or flagged errors.

Parameters:
- CNT_W, 8, width of the saturating mismatch (fault-event) counter.
- SWAP_EN, 1, when 1 the second evaluation drives swapped operands (B,A); when 0 it re-drives (A,B).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req0_valid  input  1  requester 0 operation valid.
- req0_a  input  4  requester 0 operand A, unsigned.
- req0_b  input  4  requester 0 operand B, unsigned.
- req0_ready  output  1  requester 0 accepted this cycle.
- req1_valid  input  1  requester 1 operation valid.
- req1_a  input  4  requester 1 operand A, unsigned.
- req1_b  input  4  requester 1 operand B, unsigned.
- req1_ready  output  1  requester 1 accepted this cycle.
- mul_a  output  4  operand A to the shared multiplier.
- mul_b  output  4  operand B to the shared multiplier.
- mul_p  input  8  product returned by the multiplier, combinational in the same cycle.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response consumer ready.
- rsp_id  output  1  requester index the response belongs to.
- rsp_p  output  8  voted product.
- rsp_corr  output  1  mismatch occurred and the vote corrected it.
- rsp_err  output  1  all three evaluations disagree (uncorrectable).
- err_count  output  CNT_W  saturating count of operations that saw any mismatch.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all outputs 0; mul_a=mul_b=0.
  - last_grant=1, so requester 0 wins the first contention.
  - err_count=0; captured products cleared.
- FSM states: IDLE, RUN1, RUN2, RUN3, RESP.
- IDLE:
  - Round-robin grant. If exactly one requester is valid, grant it. If both are valid, grant the one not equal to last_grant.
  - reqX_ready is a combinational function of state==IDLE and the grant; at most one ready is high.
  - On a handshake (valid&&ready): latch a, b, id; set last_grant=id; go to RUN1.
  - mul_a and mul_b are 0 in IDLE.
- RUN1: drive mul_a=a, mul_b=b; capture p1=mul_p at the clock edge; go to RUN2.
- RUN2: drive (b,a) if SWAP_EN, else (a,b); capture p2.
  - If p2==p1: result=p1, corr=0, err=0; go to RESP.
  - Otherwise go to RUN3.
- RUN3: drive (a,b); capture p3.
  - If p3==p1 or p3==p2: result=p3, corr=1.
  - Otherwise: result=p3, err=1.
  - Go to RESP.
- err_count increments by 1 on entry to RUN3 and saturates at 2^CNT_W-1, with no wrap. It is never cleared except by reset.
- RESP:
  - rsp_valid=1; rsp_id, rsp_p, rsp_corr and rsp_err are stable until the handshake.
  - On rsp_ready=1, return to IDLE next cycle; rsp_valid drops.
  - No new request is accepted in RESP, even in the handshake cycle.
- Latency, with acceptance at cycle T:
  - No mismatch: rsp_valid at T+3.
  - Mismatch: rsp_valid at T+4.
  - Minimum issue interval is 4 cycles.
- The response does not depend on requester inputs after acceptance; operand changes after the handshake are ignored.
- Reset asserted mid-operation (any state) aborts the operation with no response and returns to the reset values above.
- The multiplier is purely combinational; no cycle budget is allowed for settling beyond one clock period.

Test Plan:
- Basic run: req0 a=13, b=11, ideal multiplier, rsp_ready=1 -> accepted at T; rsp_valid at T+3 with rsp_p=143, rsp_id=0, corr=0, err=0, err_count=0.
- Contention: req0 and req1 held valid continuously, with req0 (2,3) and req1 (15,15) -> grants alternate 0,1,0,1; responses 6 then 225, each 4 cycles apart.
- Corrected fault: bench flips bit 0 of mul_p during RUN2 only, on 7*9 -> RUN3 entered; rsp_p=63, corr=1, err=0, valid at T+4; err_count=1.
- Uncorrectable fault: bench returns 63, 62, 61 in RUN1, RUN2, RUN3 -> rsp_p=61, err=1, corr=0.
- Backpressure: rsp_ready held 0 for 5 cycles in RESP -> outputs stable, both readys 0; one cycle after rsp_ready=1, state is IDLE.
- Reset and saturation: rst_n pulsed low during RUN2 -> no rsp_valid and all outputs 0. With CNT_W=2 and 5 faulted operations -> err_count=3.

Source files
------------

// File: rtl/mult4u_tr_sched.sv
// Time-redundant scheduler around one shared combinational 4x4 multiplier.
// Each operation is evaluated (A,B), then (B,A), and a voting third pass runs on mismatch.
module mult4u_tr_sched #(
  parameter int CNT_W   = 8,
  parameter bit SWAP_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [3:0]       req0_a,
  input  logic [3:0]       req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [3:0]       req1_a,
  input  logic [3:0]       req1_b,
  output logic             req1_ready,
  output logic [3:0]       mul_a,
  output logic [3:0]       mul_b,
  input  logic [7:0]       mul_p,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [7:0]       rsp_p,
  output logic             rsp_corr,
  output logic             rsp_err,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic [2:0] {IDLE, RUN1, RUN2, RUN3, RESP} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             r_last_grant;
  logic             r_id;
  logic [3:0]       r_a;
  logic [3:0]       r_b;
  logic [7:0]       r_p1;
  logic [7:0]       r_p2;
  logic [7:0]       r_res;
  logic             r_corr;
  logic             r_err;
  logic [CNT_W-1:0] r_err_cnt;

  logic w_grant0;
  logic w_grant1;
  logic w_accept;
  logic w_sel;
  logic w_match12;
  logic w_vote_ok;
  logic w_cnt_max;

  // Round robin: on contention the requester that did not win last time goes.
  assign w_grant0 = req0_valid && (!req1_valid || r_last_grant);
  assign w_grant1 = req1_valid && (!req0_valid || !r_last_grant);

  assign req0_ready = (r_state == IDLE) && w_grant0;
  assign req1_ready = (r_state == IDLE) && w_grant1;
  assign w_accept   = req0_ready || req1_ready;
  assign w_sel      = req1_ready;

  assign w_match12 = (mul_p == r_p1);
  assign w_vote_ok = (mul_p == r_p1) || (mul_p == r_p2);
  assign w_cnt_max = (r_err_cnt == {CNT_W{1'b1}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    mul_a        = 4'd0;
    mul_b        = 4'd0;
    case (r_state)
      IDLE: begin
        if (w_accept) w_state_next = RUN1;
      end
      RUN1: begin
        mul_a        = r_a;
        mul_b        = r_b;
        w_state_next = RUN2;
      end
      RUN2: begin
        mul_a        = SWAP_EN ? r_b : r_a;
        mul_b        = SWAP_EN ? r_a : r_b;
        w_state_next = w_match12 ? RESP : RUN3;
      end
      RUN3: begin
        mul_a        = r_a;
        mul_b        = r_b;
        w_state_next = RESP;
      end
      RESP: begin
        if (rsp_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
      r_id         <= 1'b0;
      r_a          <= 4'd0;
      r_b          <= 4'd0;
      r_p1         <= 8'd0;
      r_p2         <= 8'd0;
      r_res        <= 8'd0;
      r_corr       <= 1'b0;
      r_err        <= 1'b0;
      r_err_cnt    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a          <= w_sel ? req1_a : req0_a;
            r_b          <= w_sel ? req1_b : req0_b;
            r_id         <= w_sel;
            r_last_grant <= w_sel;
          end
        end
        RUN1: r_p1 <= mul_p;
        RUN2: begin
          r_p2 <= mul_p;
          if (w_match12) begin
            r_res  <= r_p1;
            r_corr <= 1'b0;
            r_err  <= 1'b0;
          end else if (!w_cnt_max) begin
            r_err_cnt <= r_err_cnt + 1'b1;
          end
        end
        RUN3: begin
          r_res  <= mul_p;
          r_corr <= w_vote_ok;
          r_err  <= !w_vote_ok;
        end
        default: ;
      endcase
    end
  end

  // Response fields read as zero outside RESP so idle outputs match reset.
  assign rsp_valid = (r_state == RESP);
  assign rsp_id    = rsp_valid && r_id;
  assign rsp_p     = rsp_valid ? r_res : 8'd0;
  assign rsp_corr  = rsp_valid && r_corr;
  assign rsp_err   = rsp_valid && r_err;
  assign err_count = r_err_cnt;

endmodule

// File: tb/tb_mult4u_tr_sched.sv
// Directed bench for mult4u_tr_sched with a fault-injecting multiplier model.
module tb_mult4u_tr_sched;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [3:0] req0_a = 4'd0, req0_b = 4'd0, req1_a = 4'd0, req1_b = 4'd0;
  logic       req0_ready, req1_ready;
  logic [3:0] mul_a, mul_b;
  logic [7:0] mul_p;
  logic       rsp_valid, rsp_id, rsp_corr, rsp_err;
  logic       rsp_ready = 1'b1;
  logic [7:0] rsp_p;
  logic [1:0] err_count;

  int n_asserts = 0;
  int n_fail = 0;
  int fmode = 0;
  int phase = 0;

  mult4u_tr_sched #(.CNT_W(2), .SWAP_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_p(rsp_p),
    .rsp_corr(rsp_corr), .rsp_err(rsp_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // mode 0 ideal; mode 1 flips bit 0 in the second pass; mode 2 returns 63/62/61.
  always_comb begin
    logic [7:0] ideal;
    ideal = 8'(mul_a) * 8'(mul_b);
    mul_p = ideal;
    if (fmode == 1 && phase == 2) mul_p = ideal ^ 8'h01;
    if (fmode == 2) begin
      if (phase == 1) mul_p = 8'd63;
      else if (phase == 2) mul_p = 8'd62;
      else if (phase == 3) mul_p = 8'd61;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic run_op(input int id, input logic [3:0] a, input logic [3:0] b, input int mode,
                        input logic [7:0] ep, input logic ec, input logic ee, input int elat,
                        input logic [1:0] ecnt, input int hold);
    int lat;
    fmode = mode;
    phase = 0;
    rsp_ready = (hold == 0);
    if (id == 0) begin
      req0_valid = 1'b1; req0_a = a; req0_b = b;
    end else begin
      req1_valid = 1'b1; req1_a = a; req1_b = b;
    end
    #1;
    chk("ready", (id == 0) ? req0_ready : req1_ready, 1);
    chk("other_ready", (id == 0) ? req1_ready : req0_ready, 0);
    tick;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = ~a; req0_b = ~b; req1_a = ~a; req1_b = ~b;
    lat = 1;
    phase = 1;
    while (1) begin
      if (lat == 1) begin
        chk("run1_mul_a", mul_a, a);
        chk("run1_mul_b", mul_b, b);
      end
      if (lat == 2) begin
        chk("run2_mul_a", mul_a, b);
        chk("run2_mul_b", mul_b, a);
      end
      if (lat == 3 && elat == 4) begin
        chk("run3_mul_a", mul_a, a);
        chk("run3_mul_b", mul_b, b);
      end
      if (rsp_valid || lat >= 8) break;
      tick;
      lat++;
      phase = lat;
    end
    phase = 0;
    chk("latency", lat, elat);
    chk("rsp_p", rsp_p, ep);
    chk("rsp_id", rsp_id, id);
    chk("rsp_corr", rsp_corr, ec);
    chk("rsp_err", rsp_err, ee);
    chk("err_count", err_count, ecnt);
    for (int h = 0; h < hold; h++) begin
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      chk("bp_valid", rsp_valid, 1);
      chk("bp_p", rsp_p, ep);
      chk("bp_id", rsp_id, id);
      chk("bp_readys", {req0_ready, req1_ready}, 0);
      tick;
    end
    rsp_ready = 1'b1;
    tick;
    chk("rsp_drop", rsp_valid, 0);
    if (hold > 0) chk("idle_after_bp", req0_ready | req1_ready, 1);
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    $display("op id=%0d a=%0d b=%0d mode=%0d lat=%0d p=%0d cnt=%0d", id, a, b, mode, lat, ep, err_count);
  endtask

  initial begin
    #2;
    chk("rst_valid", rsp_valid, 0);
    chk("rst_mul_a", mul_a, 0);
    chk("rst_mul_b", mul_b, 0);
    chk("rst_p", rsp_p, 0);
    chk("rst_cnt", err_count, 0);
    chk("rst_readys", {req0_ready, req1_ready}, 0);
    tick;
    rst_n = 1'b1;
    tick;

    // Contention: both requesters held valid; grants alternate starting with 0.
    req0_valid = 1'b1; req0_a = 4'd2;  req0_b = 4'd3;
    req1_valid = 1'b1; req1_a = 4'd15; req1_b = 4'd15;
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("cont_r0", req0_ready, (k % 2) == 0);
      chk("cont_r1", req1_ready, (k % 2) == 1);
      tick;
      tick;
      chk("cont_early", rsp_valid, 0);
      tick;
      chk("cont_valid", rsp_valid, 1);
      chk("cont_id", rsp_id, k % 2);
      chk("cont_p", rsp_p, (k % 2) ? 225 : 6);
      chk("cont_resp_readys", {req0_ready, req1_ready}, 0);
      $display("contention op %0d id=%0d p=%0d", k, rsp_id, rsp_p);
      tick;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;

    run_op(0, 4'd13, 4'd11, 0, 8'd143, 1'b0, 1'b0, 3, 2'd0, 0);
    run_op(1, 4'd7,  4'd9,  1, 8'd63,  1'b1, 1'b0, 4, 2'd1, 0);
    run_op(0, 4'd7,  4'd9,  2, 8'd61,  1'b0, 1'b1, 4, 2'd2, 0);
    run_op(1, 4'd5,  4'd6,  0, 8'd30,  1'b0, 1'b0, 3, 2'd2, 5);
    run_op(0, 4'd3,  4'd4,  1, 8'd12,  1'b1, 1'b0, 4, 2'd3, 0);
    run_op(1, 4'd3,  4'd4,  1, 8'd12,  1'b1, 1'b0, 4, 2'd3, 0);
    run_op(0, 4'd3,  4'd4,  1, 8'd12,  1'b1, 1'b0, 4, 2'd3, 0);

    // Reset asserted during the second pass aborts the operation.
    fmode = 0;
    req0_valid = 1'b1; req0_a = 4'd4; req0_b = 4'd4;
    tick;
    req0_valid = 1'b0;
    tick;
    chk("pre_rst_run2", mul_a, 4);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", rsp_valid, 0);
    chk("mid_rst_mul_a", mul_a, 0);
    chk("mid_rst_mul_b", mul_b, 0);
    chk("mid_rst_p", rsp_p, 0);
    chk("mid_rst_cnt", err_count, 0);
    tick;
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick;
      chk("post_rst_valid", rsp_valid, 0);
      chk("post_rst_mul_a", mul_a, 0);
    end
    chk("post_rst_cnt", err_count, 0);
    $display("reset abort checked");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
